// File: rtl/bp_sound_mailbox.sv
// Blue Print sound-command mailbox: queues main-CPU command writes and hands them
// to the sound CPU one at a time, each announced by a fixed-length NMI pulse.
module bp_sound_mailbox #(
  parameter int DEPTH      = 4,
  parameter int NMI_HOLD   = 64,
  parameter int RD_TIMEOUT = 49152
) (
  input  logic                     clk_49m,
  input  logic                     reset,
  input  logic [7:0]               main_cmd,
  input  logic                     main_cmd_wr,
  input  logic                     snd_latch_rd,
  input  logic                     snd_nmi_en,
  input  logic                     pause,
  input  logic                     ovf_clr,
  output logic [7:0]               snd_latch_data,
  output logic                     snd_nmi_n,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = (NMI_HOLD > 1) ? $clog2(NMI_HOLD) : 1;
  localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  localparam logic [LW-1:0] FULL      = LW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(NMI_HOLD - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_RD
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_next;
  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo_next;
  logic          r_rd_seen;
  logic          w_rd_seen_next;
  logic          r_nmi_n;
  logic          w_nmi_n_next;
  logic          w_launch;
  logic          w_tmo_set;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [7:0]    r_latch;
  logic          r_overflow;
  logic          r_timeout;
  logic          w_push;
  logic          w_ovf_set;

  // A full FIFO still accepts a write when the sequencer pops in the same cycle.
  assign w_push    = main_cmd_wr && ((r_level != FULL) || w_launch);
  assign w_ovf_set = main_cmd_wr && !w_push;

  always_comb begin
    w_state_next   = r_state;
    w_hold_next    = r_hold;
    w_tmo_next     = r_tmo;
    w_rd_seen_next = r_rd_seen;
    w_nmi_n_next   = r_nmi_n;
    w_launch       = 1'b0;
    w_tmo_set      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_level != '0) && snd_nmi_en && !pause) begin
          w_launch       = 1'b1;
          w_state_next   = S_ASSERT;
          w_hold_next    = HOLD_LOAD;
          w_rd_seen_next = 1'b0;
          w_nmi_n_next   = 1'b0;
        end
      end
      S_ASSERT: begin
        if (snd_latch_rd) begin
          w_rd_seen_next = 1'b1;
        end
        if (r_hold == '0) begin
          w_state_next = S_WAIT_RD;
          w_nmi_n_next = 1'b1;
          w_tmo_next   = TMO_LOAD;
        end else begin
          w_hold_next = r_hold - 1'b1;
        end
      end
      S_WAIT_RD: begin
        if (r_rd_seen || snd_latch_rd) begin
          w_state_next = S_IDLE;
        end else if (r_tmo == '0) begin
          w_state_next = S_IDLE;
          w_tmo_set    = 1'b1;
        end else begin
          w_tmo_next = r_tmo - 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_tmo     <= '0;
      r_rd_seen <= 1'b0;
      r_nmi_n   <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_hold    <= w_hold_next;
      r_tmo     <= w_tmo_next;
      r_rd_seen <= w_rd_seen_next;
      r_nmi_n   <= w_nmi_n_next;
    end
  end

  // Storage needs no reset; the level counter alone decides what is valid.
  always_ff @(posedge clk_49m) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= main_cmd;
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_latch    <= 8'h00;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_launch) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_latch  <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_launch})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_tmo_set) begin
        r_timeout <= 1'b1;
      end else if (ovf_clr) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign snd_latch_data = r_latch;
  assign snd_nmi_n      = r_nmi_n;
  assign fifo_level     = r_level;
  assign overflow       = r_overflow;
  assign timeout        = r_timeout;

endmodule

// File: tb/tb_bp_sound_mailbox.sv
// Self-checking bench for bp_sound_mailbox: random command streams checked against a
// transaction-level model of delivery order, NMI timing and queue occupancy.
module tb_bp_sound_mailbox;

  localparam int DEPTH      = 4;
  localparam int NMI_HOLD   = 64;
  localparam int RD_TIMEOUT = 200;

  logic       clk_49m;
  logic       reset;
  logic [7:0] main_cmd;
  logic       main_cmd_wr;
  logic       snd_latch_rd;
  logic       snd_nmi_en;
  logic       pause;
  logic       ovf_clr;
  logic [7:0] snd_latch_data;
  logic       snd_nmi_n;
  logic [$clog2(DEPTH):0] fifo_level;
  logic       overflow;
  logic       timeout;

  int nTests;
  int nFail;

  logic [7:0] expQ[$];
  int         expW[$];
  int         wrCyc[$];
  logic [7:0] wrDat[$];
  int         modelLevel;

  bp_sound_mailbox #(
    .DEPTH(DEPTH),
    .NMI_HOLD(NMI_HOLD),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk_49m(clk_49m),
    .reset(reset),
    .main_cmd(main_cmd),
    .main_cmd_wr(main_cmd_wr),
    .snd_latch_rd(snd_latch_rd),
    .snd_nmi_en(snd_nmi_en),
    .pause(pause),
    .ovf_clr(ovf_clr),
    .snd_latch_data(snd_latch_data),
    .snd_nmi_n(snd_nmi_n),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .timeout(timeout)
  );

  initial clk_49m = 1'b0;
  always #5 clk_49m = ~clk_49m;

  task automatic step();
    @(posedge clk_49m);
    #1;
  endtask

  // Runs queued writes and answers every NMI with a read inside the pulse; each NMI
  // must fall at max(previous fall + NMI_HOLD + 2, write edge + 1) carrying the oldest command.
  task automatic deliverLoop(input int budget);
    int c = 0;
    int lastFall = -100000;
    int readAt = -1;
    int tail = NMI_HOLD + 4;
    int levelErrs = 0;
    int lvlAct = 0;
    int lvlExp = 0;
    int expFall;
    int tmp;
    logic [7:0] tmpD;
    logic prevN;
    prevN = snd_nmi_n;
    while (c < budget && !(expQ.size() == 0 && wrCyc.size() == 0 && tail <= 0)) begin
      main_cmd_wr  = 1'b0;
      snd_latch_rd = (c == readAt);
      if (wrCyc.size() > 0 && wrCyc[0] == c) begin
        tmp  = wrCyc.pop_front();
        tmpD = wrDat.pop_front();
        main_cmd    = tmpD;
        main_cmd_wr = 1'b1;
        expQ.push_back(tmpD);
        expW.push_back(c);
        modelLevel++;
      end
      step();
      if (prevN && !snd_nmi_n) begin
        nTests++;
        if (expQ.size() == 0) begin
          nFail++;
          $display("[TB] FAIL unexpected_nmi: NMI at cycle %0d, expected none", c);
        end else begin
          expFall = lastFall + NMI_HOLD + 2;
          if (expW[0] + 1 > expFall) expFall = expW[0] + 1;
          if (snd_latch_data !== expQ[0]) begin
            nFail++;
            $display("[TB] FAIL deliver_data: got %02h expected %02h", snd_latch_data, expQ[0]);
          end
          nTests++;
          if (c != expFall) begin
            nFail++;
            $display("[TB] FAIL nmi_fall_time: got cycle %0d expected cycle %0d", c, expFall);
          end
          tmpD = expQ.pop_front();
          tmp  = expW.pop_front();
          modelLevel--;
        end
        lastFall = c;
        readAt   = c + 1 + int'($urandom_range(0, NMI_HOLD - 2));
        tail     = NMI_HOLD + 4;
      end else if (expQ.size() == 0 && wrCyc.size() == 0) begin
        tail--;
      end
      if (int'(fifo_level) != modelLevel) begin
        if (levelErrs == 0) begin
          lvlAct = int'(fifo_level);
          lvlExp = modelLevel;
        end
        levelErrs++;
      end
      prevN = snd_nmi_n;
      c++;
    end
    main_cmd_wr  = 1'b0;
    snd_latch_rd = 1'b0;
    nTests++;
    if (expQ.size() != 0 || wrCyc.size() != 0) begin
      nFail++;
      $display("[TB] FAIL deliver_incomplete: %0d commands left, expected 0",
               expQ.size() + wrCyc.size());
    end
    nTests++;
    if (levelErrs != 0) begin
      nFail++;
      $display("[TB] FAIL fifo_level_track: got %0d expected %0d (%0d bad cycles)",
               lvlAct, lvlExp, levelErrs);
    end
    nTests++;
    if (snd_nmi_n !== 1'b1 || fifo_level !== '0) begin
      nFail++;
      $display("[TB] FAIL deliver_end_idle: nmi_n=%0b level=%0d expected nmi_n=1 level=0",
               snd_nmi_n, fifo_level);
    end
    expQ.delete();
    expW.delete();
    wrCyc.delete();
    wrDat.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    nTests++;
    if (snd_nmi_n !== 1'b1) begin
      nFail++; $display("[TB] FAIL reset_nmi: got %0b expected 1", snd_nmi_n);
    end
    nTests++;
    if (snd_latch_data !== 8'h00) begin
      nFail++; $display("[TB] FAIL reset_latch: got %02h expected 00", snd_latch_data);
    end
    nTests++;
    if (fifo_level !== '0) begin
      nFail++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level);
    end
    nTests++;
    if (overflow !== 1'b0 || timeout !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_flags: got ovf=%0b tmo=%0b expected 0 0", overflow, timeout);
    end
    reset = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single();
    int lowCnt;
    main_cmd    = 8'h5A;
    main_cmd_wr = 1'b1;
    step();
    main_cmd_wr = 1'b0;
    nTests++;
    if (fifo_level !== 1 || snd_nmi_n !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL single_after_e0: level=%0d nmi_n=%0b expected 1 1", fifo_level, snd_nmi_n);
    end
    step();
    nTests++;
    if (snd_nmi_n !== 1'b0 || snd_latch_data !== 8'h5A || fifo_level !== 0) begin
      nFail++;
      $display("[TB] FAIL single_after_e1: nmi_n=%0b latch=%02h level=%0d expected 0 5a 0",
               snd_nmi_n, snd_latch_data, fifo_level);
    end
    lowCnt = 1;
    while (snd_nmi_n == 1'b0 && lowCnt < 1000) begin
      snd_latch_rd = (lowCnt == 10);
      step();
      if (snd_nmi_n == 1'b0) lowCnt++;
    end
    snd_latch_rd = 1'b0;
    nTests++;
    if (lowCnt != NMI_HOLD) begin
      nFail++; $display("[TB] FAIL single_nmi_width: got %0d expected %0d", lowCnt, NMI_HOLD);
    end
    repeat (2) step();
    snd_latch_rd = 1'b1;
    step();
    snd_latch_rd = 1'b0;
    step();
    nTests++;
    if (snd_latch_data !== 8'h5A || snd_nmi_n !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL single_latch_hold: latch=%02h nmi_n=%0b expected 5a 1",
               snd_latch_data, snd_nmi_n);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      wrCyc.push_back(i);
      wrDat.push_back(8'(i + 1));
    end
    modelLevel = 0;
    deliverLoop(5 * (NMI_HOLD + 2) + 50);
    for (int i = 0; i < DEPTH; i++) begin
      wrCyc.push_back(i);
      wrDat.push_back(8'($urandom_range(0, 255)));
    end
    modelLevel = 0;
    deliverLoop((DEPTH + 2) * (NMI_HOLD + 2) + 50);
  endtask

  task automatic test_random_stream();
    int cyc;
    int n;
    for (int r = 0; r < 4; r++) begin
      n   = int'($urandom_range(1, DEPTH));
      cyc = int'($urandom_range(0, 5));
      for (int i = 0; i < n; i++) begin
        wrCyc.push_back(cyc);
        wrDat.push_back(8'($urandom_range(0, 255)));
        cyc += 1 + int'($urandom_range(0, 90));
      end
      modelLevel = 0;
      deliverLoop(cyc + (n + 2) * (NMI_HOLD + 2) + 200);
    end
  endtask

  task automatic test_pause();
    int lowCnt;
    pause       = 1'b1;
    main_cmd    = 8'h10;
    main_cmd_wr = 1'b1;
    step();
    main_cmd_wr = 1'b0;
    repeat (5) step();
    nTests++;
    if (snd_nmi_n !== 1'b1 || fifo_level !== 1) begin
      nFail++;
      $display("[TB] FAIL pause_hold: nmi_n=%0b level=%0d expected 1 1", snd_nmi_n, fifo_level);
    end
    pause = 1'b0;
    step();
    nTests++;
    if (snd_nmi_n !== 1'b0 || snd_latch_data !== 8'h10 || fifo_level !== 0) begin
      nFail++;
      $display("[TB] FAIL pause_release: nmi_n=%0b latch=%02h level=%0d expected 0 10 0",
               snd_nmi_n, snd_latch_data, fifo_level);
    end
    pause      = 1'b1;
    snd_nmi_en = 1'b0;
    lowCnt = 1;
    while (snd_nmi_n == 1'b0 && lowCnt < 1000) begin
      snd_latch_rd = (lowCnt == 5);
      step();
      if (snd_nmi_n == 1'b0) lowCnt++;
    end
    snd_latch_rd = 1'b0;
    pause        = 1'b0;
    snd_nmi_en   = 1'b1;
    nTests++;
    if (lowCnt != NMI_HOLD) begin
      nFail++; $display("[TB] FAIL pause_no_shorten: got %0d expected %0d", lowCnt, NMI_HOLD);
    end
    repeat (4) step();
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    snd_nmi_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i < DEPTH) begin
        expQ.push_back(d);
        expW.push_back(-1);
      end
      main_cmd    = d;
      main_cmd_wr = 1'b1;
      step();
    end
    main_cmd_wr = 1'b0;
    nTests++;
    if (fifo_level !== DEPTH || overflow !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL ovf_set: level=%0d ovf=%0b expected %0d 1", fifo_level, overflow, DEPTH);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    nTests++;
    if (overflow !== 1'b0) begin
      nFail++; $display("[TB] FAIL ovf_clear: got %0b expected 0", overflow);
    end
    main_cmd    = 8'($urandom_range(0, 255));
    main_cmd_wr = 1'b1;
    ovf_clr     = 1'b1;
    step();
    main_cmd_wr = 1'b0;
    ovf_clr     = 1'b0;
    nTests++;
    if (overflow !== 1'b1 || fifo_level !== DEPTH) begin
      nFail++;
      $display("[TB] FAIL ovf_set_wins: ovf=%0b level=%0d expected 1 %0d", overflow, fifo_level, DEPTH);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr    = 1'b0;
    modelLevel = DEPTH;
    snd_nmi_en = 1'b1;
    deliverLoop((DEPTH + 3) * (NMI_HOLD + 2) + 50);
  endtask

  task automatic test_timeout();
    logic [7:0] a;
    logic [7:0] b;
    int k;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    main_cmd    = a;
    main_cmd_wr = 1'b1;
    step();
    k = 0;
    main_cmd = b;
    step();
    k = 1;
    main_cmd_wr = 1'b0;
    while (timeout == 1'b0 && k < NMI_HOLD + RD_TIMEOUT + 100) begin
      step();
      k++;
    end
    nTests++;
    if (k != NMI_HOLD + RD_TIMEOUT + 1) begin
      nFail++;
      $display("[TB] FAIL timeout_time: got %0d edges expected %0d", k, NMI_HOLD + RD_TIMEOUT + 1);
    end
    step();
    nTests++;
    if (snd_nmi_n !== 1'b0 || snd_latch_data !== b) begin
      nFail++;
      $display("[TB] FAIL timeout_next_cmd: nmi_n=%0b latch=%02h expected 0 %02h",
               snd_nmi_n, snd_latch_data, b);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    nTests++;
    if (timeout !== 1'b0) begin
      nFail++; $display("[TB] FAIL timeout_clear: got %0b expected 0", timeout);
    end
    snd_latch_rd = 1'b1;
    step();
    snd_latch_rd = 1'b0;
    repeat (NMI_HOLD + 4) step();
    nTests++;
    if (snd_nmi_n !== 1'b1 || timeout !== 1'b0 || fifo_level !== 0) begin
      nFail++;
      $display("[TB] FAIL timeout_read_ok: nmi_n=%0b tmo=%0b level=%0d expected 1 0 0",
               snd_nmi_n, timeout, fifo_level);
    end
  endtask

  task automatic test_reset_mid();
    int lowCnt;
    for (int i = 0; i < 3; i++) begin
      main_cmd    = 8'($urandom_range(1, 255));
      main_cmd_wr = 1'b1;
      step();
    end
    main_cmd_wr = 1'b0;
    repeat (10) step();
    nTests++;
    if (snd_nmi_n !== 1'b0 || fifo_level !== 2) begin
      nFail++;
      $display("[TB] FAIL rstmid_pre: nmi_n=%0b level=%0d expected 0 2", snd_nmi_n, fifo_level);
    end
    #2;
    reset = 1'b0;
    #1;
    nTests++;
    if (snd_nmi_n !== 1'b1 || fifo_level !== 0 || snd_latch_data !== 8'h00) begin
      nFail++;
      $display("[TB] FAIL rstmid_async: nmi_n=%0b level=%0d latch=%02h expected 1 0 00",
               snd_nmi_n, fifo_level, snd_latch_data);
    end
    repeat (3) step();
    reset = 1'b1;
    lowCnt = 0;
    for (int i = 0; i < 2 * (NMI_HOLD + 2); i++) begin
      step();
      if (snd_nmi_n == 1'b0) lowCnt++;
    end
    nTests++;
    if (lowCnt != 0 || fifo_level !== 0) begin
      nFail++;
      $display("[TB] FAIL rstmid_no_nmi: low cycles=%0d level=%0d expected 0 0", lowCnt, fifo_level);
    end
  endtask

  initial begin
    nTests       = 0;
    nFail        = 0;
    modelLevel   = 0;
    reset        = 1'b0;
    main_cmd     = 8'h00;
    main_cmd_wr  = 1'b0;
    snd_latch_rd = 1'b0;
    snd_nmi_en   = 1'b1;
    pause        = 1'b0;
    ovf_clr      = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_random_stream();
    test_pause();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
